// File: rtl/axi_window_pkg.sv
// Shared AXI codes and FSM state type for the window RAM responder.
package axi_window_pkg;
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {BUSY, IDLE, READ} state_e;
endpackage

// File: rtl/window_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port with enable.
// The read is read-first, and the read data is held in a registered output.
module window_ram_sdp #(
  parameter int AW = 7,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Output register only moves on an enabled read, so it holds during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/axi_window_ram_responder.sv
// AXI4 read-only slave serving burst reads from the window RAM.
// The window logic fills the RAM through a plain write port.
module axi_window_ram_responder
  import axi_window_pkg::*;
#(
  parameter int DATA_BYTE_WIDTH = 32,
  parameter int DATA_BYTE_SHIFT = 5,
  parameter int RAM_DEPTH_INDEX = 7,
  parameter int ID_WIDTH        = 4,
  parameter int RST_BUSY_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [RAM_DEPTH_INDEX-1:0]   wr_addr,
  input  logic [DATA_BYTE_WIDTH*8-1:0] wr_data,
  output logic                         rsta_busy,
  output logic                         rstb_busy,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [31:0]                  s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_BYTE_WIDTH*8-1:0] s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready
);
  localparam int DW     = DATA_BYTE_WIDTH * 8;
  localparam int HI_LSB = DATA_BYTE_SHIFT + RAM_DEPTH_INDEX;
  localparam int CW     = $clog2(RST_BUSY_CYCLES + 1);

  state_e                     state_q, state_d;
  logic                       busy_q, busy_d;
  logic [CW-1:0]              busy_cnt_q, busy_cnt_d;
  logic [ID_WIDTH-1:0]        rid_q, rid_d;
  logic [7:0]                 len_q, len_d;
  logic [1:0]                 burst_q, burst_d;
  logic [RAM_DEPTH_INDEX-1:0] idx_q, idx_d;
  logic                       err_q, err_d;
  logic [8:0]                 issued_q, issued_d;
  logic                       rvalid_q, rvalid_d;
  logic                       rlast_q, rlast_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic                       beat_err_q, beat_err_d;
  logic                       issue;
  logic [DW-1:0]              ram_rdata;
  logic                       unused_addr_bits;

  // Byte offset within a beat carries no information for full-width beats.
  assign unused_addr_bits = ^s_axi_araddr[DATA_BYTE_SHIFT-1:0];

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    rid_d      = rid_q;
    len_d      = len_q;
    burst_d    = burst_q;
    idx_d      = idx_q;
    err_d      = err_q;
    issued_d   = issued_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    beat_err_d = beat_err_q;
    issue      = 1'b0;
    case (state_q)
      BUSY: begin
        if (busy_cnt_q == CW'(RST_BUSY_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (s_axi_arvalid) begin
          rid_d    = s_axi_arid;
          len_d    = s_axi_arlen;
          burst_d  = s_axi_arburst;
          idx_d    = s_axi_araddr[HI_LSB-1:DATA_BYTE_SHIFT];
          // Address bits above the RAM make every beat an error, like a bad size/burst.
          err_d    = (s_axi_arsize != 3'(DATA_BYTE_SHIFT)) ||
                     (s_axi_arburst == AXI_BURST_WRAP) || (s_axi_arburst == 2'd3) ||
                     (s_axi_araddr[31:HI_LSB] != '0);
          issued_d = '0;
          state_d  = READ;
        end
      end
      READ: begin
        if (rvalid_q && s_axi_rready && rlast_q) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else if ((!rvalid_q || s_axi_rready) && (issued_q <= {1'b0, len_q})) begin
          issue      = 1'b1;
          rvalid_d   = 1'b1;
          rlast_d    = (issued_q[7:0] == len_q);
          rresp_d    = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          beat_err_d = err_q;
          issued_d   = issued_q + 1'b1;
          if (burst_q == AXI_BURST_INCR) idx_d = idx_q + 1'b1;
        end else if (rvalid_q && s_axi_rready) begin
          rvalid_d = 1'b0;
        end
      end
      default: state_d = BUSY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUSY;
      busy_q     <= 1'b1;
      busy_cnt_q <= '0;
      rid_q      <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      issued_q   <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= AXI_RESP_OKAY;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      rid_q      <= rid_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      issued_q   <= issued_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      beat_err_q <= beat_err_d;
    end
  end

  window_ram_sdp #(.AW(RAM_DEPTH_INDEX), .DW(DW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en && !busy_q),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (issue),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

  assign rsta_busy     = busy_q;
  assign rstb_busy     = busy_q;
  assign s_axi_arready = (state_q == IDLE);
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = beat_err_q ? '0 : ram_rdata;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;
endmodule

// File: tb/tb_axi_window_ram_responder.sv
// Self-checking bench for axi_window_ram_responder: a RAM image plus
// address/error rules give the expected beats of every burst.
module tb_axi_window_ram_responder;
  localparam int DW = 256;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [6:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsta_busy, rstb_busy;
  logic [3:0]    arid = '0;
  logic [31:0]   araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          arvalid = 1'b0, arready;
  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready = 1'b0;

  axi_window_ram_responder dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsta_busy(rsta_busy), .rstb_busy(rstb_busy),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [128];
  logic [DW-1:0] exp_data[$], got_data[$];
  logic [1:0]    exp_resp[$], got_resp[$];
  logic          got_last[$];
  logic [3:0]    got_id[$];
  int vectors = 0, miscompares = 0;
  int first_lat, stall_bad, ar_bad, timeout;
  int wr_cycle = -1, abort_after = -1;
  logic [6:0]    wr_word_c = '0;
  logic [DW-1:0] wr_val_c = '0;
  logic post_ok, ab_rvalid, ab_busy, ab_arready;
  logic busy_tr [8], busyb_tr [8], ar_tr [8];

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected beats from the AXI rules: word index, FIXED/INCR, error conditions.
  task automatic build_exp(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst);
    logic err;
    int idx;
    exp_data.delete(); exp_resp.delete();
    err = (size != 3'd5) || (burst >= 2'd2) || (addr >= 32'h1000);
    for (int b = 0; b <= len; b++) begin
      idx = (burst == 2'd0) ? int'(addr[11:5]) : (int'(addr[11:5]) + b) % 128;
      exp_data.push_back(err ? '0 : mem[idx]);
      exp_resp.push_back(err ? 2'd2 : 2'd0);
    end
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] v);
    wr_en = 1'b1; wr_addr = 7'(a); wr_data = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mem[a] = v;
  endtask

  // Holds reset, releases it, and records busy/arready after each of the next 8 edges.
  task automatic release_reset(input logic wr_busy, input int a, input logic [DW-1:0] v);
    rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0; wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_en = wr_busy && (k == 3); wr_addr = 7'(a); wr_data = v;
      @(posedge clk); #1;
      busy_tr[k] = rsta_busy; busyb_tr[k] = rstb_busy; ar_tr[k] = arready;
    end
    wr_en = 1'b0;
  endtask

  // Issues one burst and collects every accepted beat; records timing observations.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int rmode);
    logic hs, done, held;
    logic [DW-1:0] h_data; logic [1:0] h_resp; logic h_last; logic [3:0] h_id;
    int cyc;
    got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
    first_lat = -1; stall_bad = 0; ar_bad = 0; post_ok = 1'b0; timeout = 0;
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (!hs) begin timeout = 1; return; end
    cyc = 0; done = 1'b0; held = 1'b0;
    h_data = '0; h_resp = '0; h_last = 1'b0; h_id = '0;
    while (!done && cyc < 600) begin
      cyc++;
      rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
      wr_en = (cyc == wr_cycle); wr_addr = wr_word_c; wr_data = wr_val_c;
      @(negedge clk);
      if (rvalid && first_lat < 0) first_lat = cyc;
      if (held && (!rvalid || rdata !== h_data || rresp !== h_resp || rlast !== h_last || rid !== h_id))
        stall_bad++;
      held = rvalid && !rready;
      h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
      if (arready) ar_bad++;
      if (rvalid && rready) begin
        got_data.push_back(rdata); got_resp.push_back(rresp);
        got_last.push_back(rlast); got_id.push_back(rid);
        if (rlast) done = 1'b1;
        if (abort_after >= 0 && got_data.size() == abort_after + 1 && !done) begin
          #1 rst_n = 1'b0;
          #1 ab_rvalid = rvalid; ab_busy = rsta_busy; ab_arready = arready;
          rready = 1'b0; wr_en = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; rready = 1'b0;
    if (!done) begin timeout = 1; return; end
    @(negedge clk);
    post_ok = (rvalid === 1'b0) && (arready === 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] keep;
    rst_n = 1'b0; #13;
    vectors++;
    if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 || rid !== 4'd0 || rresp !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: arready=%b rvalid=%b rlast=%b rid=%0d rresp=%0d, need all 0",
               arready, rvalid, rlast, rid, rresp);
    end
    vectors++;
    if (rdata !== '0 || rsta_busy !== 1'b1 || rstb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h busy=%b%b, need 0 and 11", rdata, rsta_busy, rstb_busy);
    end
    release_reset(1'b0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (busy_tr[k] !== (k < 7) || busyb_tr[k] !== (k < 7) || ar_tr[k] !== (k >= 7)) begin
        miscompares++;
        $display("FAIL busy_seq edge %0d: busy=%b%b arready=%b, need busy=%b arready=%b",
                 k + 1, busy_tr[k], busyb_tr[k], ar_tr[k], k < 7, k >= 7);
      end
    end
    for (int i = 0; i < 128; i++) write_word(i, rnd_word());
    keep = mem[20];
    release_reset(1'b1, 20, ~keep);
    vectors++;
    if (busy_tr[7] !== 1'b0 || ar_tr[7] !== 1'b1 || busy_tr[6] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_seq2: busy6=%b busy7=%b ar7=%b, need 1 0 1", busy_tr[6], busy_tr[7], ar_tr[7]);
    end
    build_exp(32'(20 << 5), 0, 3'd5, 2'd1);
    run_burst(4'd1, 32'(20 << 5), 0, 3'd5, 2'd1, 0);
    vectors++;
    if (timeout != 0 || got_data.size() != 1 || got_data[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL busy_write_ignored: beats=%0d timeout=%0d, word20 must hold %h",
               got_data.size(), timeout, keep);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 16; i++) write_word(i, DW'(32'h100 + i));
    build_exp(32'h0, 15, 3'd5, 2'd1);
    run_burst(4'd3, 32'h0, 15, 3'd5, 2'd1, 0);
    vectors++;
    if (timeout != 0 || got_data.size() != 16 || first_lat != 2 || post_ok !== 1'b1 || ar_bad != 0) begin
      miscompares++;
      $display("FAIL incr_timing: beats=%0d lat=%0d post_ok=%b ar_bad=%0d timeout=%0d, need 16 2 1 0 0",
               got_data.size(), first_lat, post_ok, ar_bad, timeout);
    end
    for (int b = 0; b < got_data.size() && b < 16; b++) begin
      vectors++;
      if (got_data[b] !== exp_data[b] || got_resp[b] !== 2'd0 || got_last[b] !== (b == 15) || got_id[b] !== 4'd3) begin
        miscompares++;
        $display("FAIL incr_beat %0d: data=%h resp=%0d last=%b id=%0d, need data=%h resp=0 last=%b id=3",
                 b, got_data[b], got_resp[b], got_last[b], got_id[b], exp_data[b], b == 15);
      end
    end
  endtask

  task automatic test_stall();
    build_exp(32'h0, 15, 3'd5, 2'd1);
    run_burst(4'd3, 32'h0, 15, 3'd5, 2'd1, 1);
    vectors++;
    if (timeout != 0 || got_data.size() != 16 || stall_bad != 0 || ar_bad != 0 || post_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_ctl: beats=%0d stall_bad=%0d ar_bad=%0d post_ok=%b timeout=%0d, need 16 0 0 1 0",
               got_data.size(), stall_bad, ar_bad, post_ok, timeout);
    end
    for (int b = 0; b < got_data.size() && b < 16; b++) begin
      vectors++;
      if (got_data[b] !== exp_data[b] || got_last[b] !== (b == 15)) begin
        miscompares++;
        $display("FAIL stall_beat %0d: data=%h last=%b, need %h last=%b",
                 b, got_data[b], got_last[b], exp_data[b], b == 15);
      end
    end
  endtask

  task automatic test_wrap_fixed();
    logic [31:0] addr_t [2] = '{32'h0FE0, 32'h40};
    int          len_t  [2] = '{2, 3};
    logic [1:0]  bst_t  [2] = '{2'd1, 2'd0};
    for (int t = 0; t < 2; t++) begin
      build_exp(addr_t[t], len_t[t], 3'd5, bst_t[t]);
      run_burst(4'(5 + t), addr_t[t], len_t[t], 3'd5, bst_t[t], 0);
      vectors++;
      if (timeout != 0 || got_data.size() != len_t[t] + 1) begin
        miscompares++;
        $display("FAIL addr_mode %0d count: beats=%0d timeout=%0d, need %0d", t, got_data.size(), timeout, len_t[t] + 1);
      end
      for (int b = 0; b < got_data.size() && b <= len_t[t]; b++) begin
        vectors++;
        if (got_data[b] !== exp_data[b] || got_resp[b] !== 2'd0 || got_id[b] !== 4'(5 + t)) begin
          miscompares++;
          $display("FAIL addr_mode %0d beat %0d: data=%h resp=%0d id=%0d, need %h 0 %0d",
                   t, b, got_data[b], got_resp[b], got_id[b], exp_data[b], 5 + t);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addr_t [4] = '{32'h0, 32'h1000, 32'h20, 32'h40};
    int          len_t  [4] = '{1, 0, 3, 1};
    logic [2:0]  siz_t  [4] = '{3'd4, 3'd5, 3'd5, 3'd5};
    logic [1:0]  bst_t  [4] = '{2'd1, 2'd1, 2'd2, 2'd3};
    for (int t = 0; t < 4; t++) begin
      build_exp(addr_t[t], len_t[t], siz_t[t], bst_t[t]);
      run_burst(4'(9 + t), addr_t[t], len_t[t], siz_t[t], bst_t[t], 0);
      vectors++;
      if (timeout != 0 || got_data.size() != len_t[t] + 1 || post_ok !== 1'b1) begin
        miscompares++;
        $display("FAIL err_case %0d count: beats=%0d post_ok=%b timeout=%0d, need %0d 1 0",
                 t, got_data.size(), post_ok, timeout, len_t[t] + 1);
      end
      for (int b = 0; b < got_data.size() && b <= len_t[t]; b++) begin
        vectors++;
        if (got_data[b] !== '0 || got_resp[b] !== 2'd2 || got_last[b] !== (b == len_t[t])) begin
          miscompares++;
          $display("FAIL err_case %0d beat %0d: data=%h resp=%0d last=%b, need 0 2 %b",
                   t, b, got_data[b], got_resp[b], got_last[b], b == len_t[t]);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] old5, new5;
    old5 = mem[5]; new5 = rnd_word();
    build_exp(32'h0, 7, 3'd5, 2'd1);
    wr_cycle = 6; wr_word_c = 7'd5; wr_val_c = new5;
    run_burst(4'd7, 32'h0, 7, 3'd5, 2'd1, 0);
    wr_cycle = -1;
    mem[5] = new5;
    vectors++;
    if (timeout != 0 || got_data.size() != 8 || got_data[5] !== old5) begin
      miscompares++;
      $display("FAIL collision_old: beats=%0d word5=%h, need 8 beats and %h",
               got_data.size(), got_data.size() > 5 ? got_data[5] : '0, old5);
    end
    run_burst(4'd7, 32'(5 << 5), 0, 3'd5, 2'd1, 0);
    vectors++;
    if (timeout != 0 || got_data.size() != 1 || got_data[0] !== new5) begin
      miscompares++;
      $display("FAIL collision_new: beats=%0d, word5 need %h", got_data.size(), new5);
    end
  endtask

  task automatic test_abort();
    abort_after = 3;
    run_burst(4'd8, 32'h0, 10, 3'd5, 2'd1, 0);
    abort_after = -1;
    vectors++;
    if (ab_rvalid !== 1'b0 || ab_busy !== 1'b1 || ab_arready !== 1'b0 || got_data.size() != 4) begin
      miscompares++;
      $display("FAIL abort_state: rvalid=%b busy=%b arready=%b beats=%0d, need 0 1 0 4",
               ab_rvalid, ab_busy, ab_arready, got_data.size());
    end
    release_reset(1'b0, 0, '0);
    vectors++;
    if (busy_tr[6] !== 1'b1 || busy_tr[7] !== 1'b0 || ar_tr[7] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_seq: busy6=%b busy7=%b ar7=%b, need 1 0 1", busy_tr[6], busy_tr[7], ar_tr[7]);
    end
    build_exp(32'h20, 4, 3'd5, 2'd1);
    run_burst(4'd9, 32'h20, 4, 3'd5, 2'd1, 0);
    vectors++;
    if (timeout != 0 || got_data.size() != 5 || got_data[0] !== exp_data[0] || got_data[4] !== exp_data[4] ||
        got_last[4] !== 1'b1 || got_id[0] !== 4'd9) begin
      miscompares++;
      $display("FAIL abort_next_burst: beats=%0d timeout=%0d, need 5 correct beats id 9", got_data.size(), timeout);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr; logic [2:0] size; logic [1:0] burst; logic [3:0] id; int len;
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) write_word(int'($urandom_range(0, 127)), rnd_word());
      addr  = 32'($urandom_range(0, 127)) << 5;
      if ($urandom_range(0, 7) == 0) addr = addr | 32'h1000;
      size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd5;
      burst = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      len   = int'($urandom_range(0, 9));
      id    = 4'($urandom_range(0, 15));
      build_exp(addr, len, size, burst);
      run_burst(id, addr, len, size, burst, 2);
      vectors++;
      if (timeout != 0 || got_data.size() != len + 1 || stall_bad != 0 || ar_bad != 0) begin
        miscompares++;
        $display("FAIL rand %0d ctl: beats=%0d stall_bad=%0d ar_bad=%0d timeout=%0d, need %0d 0 0 0",
                 it, got_data.size(), stall_bad, ar_bad, timeout, len + 1);
      end
      for (int b = 0; b < got_data.size() && b <= len; b++) begin
        vectors++;
        if (got_data[b] !== exp_data[b] || got_resp[b] !== exp_resp[b] || got_last[b] !== (b == len) || got_id[b] !== id) begin
          miscompares++;
          $display("FAIL rand %0d beat %0d: data=%h resp=%0d last=%b id=%0d, need %h %0d %b %0d",
                   it, b, got_data[b], got_resp[b], got_last[b], got_id[b], exp_data[b], exp_resp[b], b == len, id);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_stall();
    test_wrap_fixed();
    test_errors();
    test_collision();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
